// File: rtl/hit_measure_ctrl.sv
// Hit measurement controller: counts coarse cycles from rise to fall, latches fine codes and
// emits one {ovf, coarse, fine_rise, fine_fall} record per hit. HIT_MEASURE_TIMEOUT_EN adds overflow timeout.
module hit_measure_ctrl #(
    parameter int unsigned COARSE_W = 16,
    parameter int unsigned FINE_W   = 8,
    parameter int unsigned OUT_W    = 1 + COARSE_W + 2 * FINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              rise_edge,
    input  logic              fall_edge,
    input  logic [FINE_W-1:0] fine_rise,
    input  logic [FINE_W-1:0] fine_fall,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              processing_ended,
    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle,
        StMeasure,
        StOutput,
        StWaitFall,
        StDone
    } state_e;

    localparam logic [COARSE_W-1:0] CntMax = '1;

    state_e              state_q, state_d;
    logic [COARSE_W-1:0] cnt_q, cnt_d;
    logic [FINE_W-1:0]   fine_rise_q, fine_rise_d;
    logic [OUT_W-1:0]    data_q, data_d;
    logic                fall_seen_q, fall_seen_d;
    logic                valid_q, valid_d;
    logic                pend_q, pend_d;
    logic                busy_q, busy_d;

    logic                handshake;
    logic [COARSE_W-1:0] cnt_sat_inc;

    // valid_q is high exactly while in StOutput
    assign handshake   = valid_q && out_ready;
    assign cnt_sat_inc = (cnt_q == CntMax) ? CntMax : cnt_q + COARSE_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fine_rise_d = fine_rise_q;
        data_d      = data_q;
        fall_seen_d = fall_seen_q;

        unique case (state_q)
            StIdle: begin
                if (rise_edge && enable) begin
                    state_d     = StMeasure;
                    cnt_d       = '0;
                    fine_rise_d = fine_rise;
                end
            end
            StMeasure: begin
                cnt_d = cnt_sat_inc;
                if (fall_edge) begin
                    // Counter starts at 0 the cycle after the rise, so +1 gives rise-to-fall span
                    state_d     = StOutput;
                    data_d      = {1'b0, cnt_sat_inc, fine_rise_q, fine_fall};
                    fall_seen_d = 1'b1;
                end
`ifdef HIT_MEASURE_TIMEOUT_EN
                else if (cnt_q == CntMax) begin
                    state_d     = StOutput;
                    data_d      = {1'b1, CntMax, fine_rise_q, {FINE_W{1'b0}}};
                    fall_seen_d = 1'b0;
                end
`endif
            end
            StOutput: begin
                if (fall_edge) begin
                    fall_seen_d = 1'b1;
                end
                if (handshake) begin
                    state_d = (fall_seen_q || fall_edge) ? StDone : StWaitFall;
                end
            end
            StWaitFall: begin
                if (fall_edge) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        valid_d = (state_d == StOutput);
        pend_d  = (state_d == StDone);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            fine_rise_q <= '0;
            data_q      <= '0;
            fall_seen_q <= 1'b0;
            valid_q     <= 1'b0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fine_rise_q <= fine_rise_d;
            data_q      <= data_d;
            fall_seen_q <= fall_seen_d;
            valid_q     <= valid_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid        = valid_q;
    assign out_data         = data_q;
    assign processing_ended = pend_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_hit_measure_ctrl.sv
// Scoreboard bench for hit_measure_ctrl: driver pushes expected records, a monitor pops and
// compares on every presented record and checks the processing_ended pulse timing.
module tb_hit_measure_ctrl;

    localparam int CW   = 4;
    localparam int FW   = 8;
    localparam int OW   = 1 + CW + 2 * FW;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HIT_MEASURE_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          rise_edge = 1'b0;
    logic          fall_edge = 1'b0;
    logic [FW-1:0] fine_rise = '0;
    logic [FW-1:0] fine_fall = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          processing_ended;
    logic          busy;

    int            total = 0;
    int            bad = 0;
    int            ready_mode = 2;  // 0 random, 1 held low, 2 held high
    logic [OW-1:0] exp_q[$];
    logic          prev_hs = 1'b0;

    hit_measure_ctrl #(
        .COARSE_W(CW),
        .FINE_W  (FW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .rise_edge       (rise_edge),
        .fall_edge       (fall_edge),
        .fine_rise       (fine_rise),
        .fine_fall       (fine_fall),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .processing_ended(processing_ended),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected record from the rise-to-fall distance k in cycles
    function automatic logic [OW-1:0] model(input int k, input logic [FW-1:0] fr,
                                            input logic [FW-1:0] ff);
        logic [CW-1:0] coarse;
        if (TIMEOUT && k > CMAX + 1) begin
            coarse = CW'(CMAX);
            return {1'b1, coarse, fr, {FW{1'b0}}};
        end
        coarse = CW'((k > CMAX) ? CMAX : k);
        return {1'b0, coarse, fr, ff};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: every presented record must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hs = 1'b0;
            end else begin
                if (!TIMEOUT) check("pe_after_handshake", 32'(processing_ended), 32'(prev_hs));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_record: got %0h want none at %0t",
                                 out_data, $time);
                    end else begin
                        check("record", 32'(out_data), 32'(exp_q[0]));
                    end
                end
                prev_hs = out_valid && out_ready;
                if (prev_hs && exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    // Caller must be mid-cycle; the rise lands in the current cycle
    task automatic hit(input int k, input logic [FW-1:0] fr, input logic [FW-1:0] ff,
                       input bit coincide, input bit noise);
        enable    = 1'b1;
        rise_edge = 1'b1;
        fall_edge = coincide;
        fine_rise = fr;
        fine_fall = 8'($urandom);
        exp_q.push_back(model(k, fr, ff));
        @(posedge clk);
        #1;
        rise_edge = 1'b0;
        fall_edge = 1'b0;
        fine_rise = 8'($urandom);
        @(negedge clk);
        check("busy_after_rise", 32'(busy), 32'd1);
        for (int i = 1; i < k; i++) begin
            @(posedge clk);
            #1;
            if (noise) begin
                rise_edge = ($urandom_range(0, 2) == 0);
                enable    = 1'($urandom_range(0, 1));
                fine_fall = 8'($urandom);
            end
        end
        rise_edge = 1'b0;
        fall_edge = 1'b1;
        fine_fall = ff;
        @(posedge clk);
        #1;
        fall_edge = 1'b0;
        fine_fall = 8'($urandom);
        enable    = 1'b1;
        if (!TIMEOUT || k <= CMAX + 1) check("valid_after_fall", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (processing_ended !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_pulse_seen", 32'(processing_ended), 32'd1);
        @(negedge clk);
        check("pulse_one_cycle", 32'(processing_ended), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_pe", 32'(processing_ended), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        hit(5, 8'h12, 8'h34, 1'b0, 1'b0);
        wait_done();

        // Backpressure: record held until ready rises
        ready_mode = 1;
        hit(7, 8'ha5, 8'h5a, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("held_valid", 32'(out_valid), 32'd1);
        end
        ready_mode = 2;
        wait_done();

        // Disabled rise ignored, then rise with coincident fall
        enable    = 1'b0;
        rise_edge = 1'b1;
        @(posedge clk);
        #1;
        rise_edge = 1'b0;
        @(negedge clk);
        check("gated_rise_ignored", 32'(busy), 32'd0);
        hit(3, 8'h77, 8'h88, 1'b1, 1'b0);
        wait_done();

        // Saturation boundaries
        hit(CMAX, 8'h01, 8'h02, 1'b0, 1'b0);
        wait_done();
        hit(CMAX + 1, 8'h03, 8'h04, 1'b0, 1'b0);
        wait_done();
        hit(CMAX + 5, 8'h05, 8'h06, 1'b0, 1'b0);
        wait_done();

        // Reset in the middle of a measurement
        enable    = 1'b1;
        rise_edge = 1'b1;
        fine_rise = 8'h3c;
        @(posedge clk);
        #1;
        rise_edge = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_pe", 32'(processing_ended), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        fall_edge = 1'b1;
        @(posedge clk);
        #1;
        fall_edge = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(busy), 32'd0);
        end
        hit(4, 8'hc3, 8'h3c, 1'b0, 1'b0);
        wait_done();

        // Randomized hits under random backpressure
        ready_mode = 0;
        for (int h = 0; h < 40; h++) begin
            if ($urandom_range(0, 3) == 0) begin
                fall_edge = 1'b1;
                @(posedge clk);
                #1;
                fall_edge = 1'b0;
                @(negedge clk);
                check("idle_fall_ignored", 32'(busy), 32'd0);
            end
            hit(int'($urandom_range(1, CMAX + 7)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 1'b1);
            wait_done();
        end
        ready_mode = 2;
        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
